// File: rtl/mips_pkg.sv
// Shared load/store types: access opcodes, sequencer states, size codes and decode helpers.
package mips_pkg;

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LBU = 3'd1,
        LH  = 3'd2,
        LHU = 3'd3,
        LW  = 3'd4,
        SB  = 3'd5,
        SH  = 3'd6,
        SW  = 3'd7
    } lsu_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } lsu_state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // True for the three store opcodes
    function automatic logic is_store(lsu_op_t op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    // True for loads whose result is sign-extended
    function automatic logic is_signed(lsu_op_t op);
        return (op == LB) || (op == LH);
    endfunction

    // Access size code of an opcode
    function automatic logic [1:0] op_size(lsu_op_t op);
        case (op)
            LB, LBU, SB: return SZ_B;
            LH, LHU, SH: return SZ_H;
            default:     return SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/lsu_be_gen.sv
// Byte-enable / extension-mode decode from opcode and low address bits.
// With LSU_MISALIGN_TRAP_EN defined it also flags misaligned half/word accesses.
module lsu_be_gen
    import mips_pkg::*;
(
    input  logic [2:0] op,
    input  logic [1:0] addr_lo,
    output logic [3:0] be,
    output logic       ue
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic       misaligned
`endif
);

    // Lane selection: halves and words ignore the low bits they cannot address
    always_comb begin
        be = 4'b0000;
        ue = is_signed(lsu_op_t'(op));
`ifdef LSU_MISALIGN_TRAP_EN
        misaligned = 1'b0;
`endif
        case (op_size(lsu_op_t'(op)))
            SZ_B: be = 4'b0001 << addr_lo;
            SZ_H: begin
                be = addr_lo[1] ? 4'b1100 : 4'b0011;
`ifdef LSU_MISALIGN_TRAP_EN
                misaligned = addr_lo[0];
`endif
            end
            default: begin
                be = 4'b1111;
`ifdef LSU_MISALIGN_TRAP_EN
                misaligned = |addr_lo;
`endif
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer between the control FSM and the data memory.
// IDLE -> ISSUE -> [WAIT] -> DONE -> IDLE; all outputs registered.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses trap
// straight to DONE with misalign/badvaddr instead of touching memory.
module lsu_mem_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [2:0]        op,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [ADDR_W-3:0] dm_addr,
    output logic [3:0]        dm_be,
    output logic [31:0]       dm_din,
    output logic              dm_wr,
    output logic              dm_ue,
    input  logic [31:0]       dm_dout,
    output logic [31:0]       mdr,
    output logic              busy,
    output logic              done,
    output logic              misalign,
    output logic [31:0]       badvaddr
);

    localparam int unsigned CNT_W = 3;

    lsu_state_t       state;
    lsu_op_t          op_q;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       be_c;
    logic             ue_c;

`ifdef LSU_MISALIGN_TRAP_EN
    logic             mis_c;

    lsu_be_gen u_be_gen (
        .op         (op),
        .addr_lo    (addr[1:0]),
        .be         (be_c),
        .ue         (ue_c),
        .misaligned (mis_c)
    );
`else
    logic             unused_addr_hi;

    lsu_be_gen u_be_gen (
        .op      (op),
        .addr_lo (addr[1:0]),
        .be      (be_c),
        .ue      (ue_c)
    );

    assign unused_addr_hi = ^addr[31:ADDR_W];
    assign misalign       = 1'b0;
    assign badvaddr       = '0;
`endif

    // Sequencer: state, memory-side registers, MDR capture and strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= LB;
            cnt      <= '0;
            dm_addr  <= '0;
            dm_be    <= '0;
            dm_din   <= '0;
            dm_wr    <= 1'b0;
            dm_ue    <= 1'b0;
            mdr      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign <= 1'b0;
            badvaddr <= '0;
`endif
        end else begin
            dm_wr    <= 1'b0;
            done     <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req) begin
`ifdef LSU_MISALIGN_TRAP_EN
                        if (mis_c) begin
                            state    <= DONE;
                            busy     <= 1'b1;
                            done     <= 1'b1;
                            misalign <= 1'b1;
                            badvaddr <= addr;
                        end else
`endif
                        begin
                            state   <= ISSUE;
                            busy    <= 1'b1;
                            op_q    <= lsu_op_t'(op);
                            dm_addr <= addr[ADDR_W-1:2];
                            dm_be   <= be_c;
                            dm_ue   <= ue_c;
                            dm_din  <= wdata;
                            dm_wr   <= is_store(lsu_op_t'(op));
                        end
                    end
                end
                ISSUE: begin
                    if (is_store(op_q)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= WAIT;
                        cnt   <= CNT_W'(RD_LAT - 1);
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        mdr   <= dm_dout;
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: instance 0 uses RD_LAT=1, instance 1 uses RD_LAT=3.
// Each instance drives its own behavioural data memory; expectations come from a
// byte-addressed reference memory and the access rules.
module tb_lsu_mem_ctrl;
    import mips_pkg::*;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned WI_W   = ADDR_W - 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst      [2];
    logic            req      [2];
    logic [2:0]      op       [2];
    logic [31:0]     addr     [2];
    logic [31:0]     wdata    [2];
    logic [WI_W-1:0] dm_addr  [2];
    logic [3:0]      dm_be    [2];
    logic [31:0]     dm_din   [2];
    logic            dm_wr    [2];
    logic            dm_ue    [2];
    logic [31:0]     dm_dout  [2];
    logic [31:0]     mdr      [2];
    logic            busy     [2];
    logic            done     [2];
    logic            misalign [2];
    logic [31:0]     badvaddr [2];

    logic [31:0] mem   [2][1024];
    logic [31:0] rpipe [2][8];
    logic        mem_init;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state
    logic [7:0]  rmem [logic [32:0]];
    logic [31:0] exp_mdr  [2];
    logic [31:0] exp_badv [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        lsu_mem_ctrl #(.RD_LAT(g == 0 ? 1 : 3), .ADDR_W(ADDR_W)) dut (
            .clk      (clk),
            .rst      (rst[g]),
            .req      (req[g]),
            .op       (op[g]),
            .addr     (addr[g]),
            .wdata    (wdata[g]),
            .dm_addr  (dm_addr[g]),
            .dm_be    (dm_be[g]),
            .dm_din   (dm_din[g]),
            .dm_wr    (dm_wr[g]),
            .dm_ue    (dm_ue[g]),
            .dm_dout  (dm_dout[g]),
            .mdr      (mdr[g]),
            .busy     (busy[g]),
            .done     (done[g]),
            .misalign (misalign[g]),
            .badvaddr (badvaddr[g])
        );
        assign dm_dout[g] = rpipe[g][(g == 0 ? 1 : 3) - 1];
    end

    function automatic int lowest_lane(logic [3:0] be);
        for (int k = 0; k < 4; k++) if (be[k]) return k;
        return 0;
    endfunction

    function automatic int lane_count(logic [3:0] be);
        int c = 0;
        for (int k = 0; k < 4; k++) if (be[k]) c++;
        return c;
    endfunction

    // Memory read: select enabled lanes, right-align, extend per ue
    function automatic logic [31:0] mem_read(logic [31:0] w, logic [3:0] be, logic ue);
        logic [31:0] s;
        s = w >> (8 * lowest_lane(be));
        case (lane_count(be))
            1:       s = ue ? {{24{s[7]}}, s[7:0]}   : {24'h0, s[7:0]};
            2:       s = ue ? {{16{s[15]}}, s[15:0]} : {16'h0, s[15:0]};
            default: s = w;
        endcase
        return s;
    endfunction

    // Memory write: place right-aligned data into enabled lanes
    function automatic logic [31:0] mem_write(logic [31:0] w, logic [3:0] be, logic [31:0] din);
        logic [31:0] r;
        int lo;
        r  = w;
        lo = lowest_lane(be);
        for (int k = 0; k < 4; k++)
            if (be[k]) r[8*k +: 8] = din[8*(k-lo) +: 8];
        return r;
    endfunction

    // Behavioural data memories with RD_LAT-deep read pipelines
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (mem_init) begin
                for (int w = 0; w < 1024; w++) mem[g][w] <= '0;
            end else if (dm_wr[g]) begin
                mem[g][dm_addr[g]] <= mem_write(mem[g][dm_addr[g]], dm_be[g], dm_din[g]);
            end
            rpipe[g][0] <= mem_read(mem[g][dm_addr[g]], dm_be[g], dm_ue[g]);
            for (int k = 1; k < 8; k++) rpipe[g][k] <= rpipe[g][k-1];
        end
    end

    function automatic int lat(int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int unsigned op_bytes(logic [2:0] o);
        if (o == LB || o == LBU || o == SB) return 1;
        if (o == LH || o == LHU || o == SH) return 2;
        return 4;
    endfunction

    function automatic logic [7:0] rd_byte(int i, logic [31:0] a);
        logic [32:0] k;
        k = {1'(i), a};
        if (rmem.exists(k)) return rmem[k];
        return 8'h00;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One complete access on instance i, checked against the reference rules
    task automatic do_txn(input int i, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] wd, output logic [3:0] be_seen, output int done_cyc);
        int unsigned n;
        logic [31:0] base, v;
        logic        st, sg, trap, mis_seen;
        logic [3:0]  ebe;
        int          exp_cyc, wr_cnt;
        n    = op_bytes(o);
        base = a & ~(32'(n) - 32'd1);
        st   = (o == SB) || (o == SH) || (o == SW);
        sg   = (o == LB) || (o == LH);
        trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        trap = (a != base);
`endif
        ebe = 4'(((32'd1 << n) - 32'd1) << base[1:0]);
        v   = '0;
        for (int b = 0; b < int'(n); b++) v[8*b +: 8] = rd_byte(i, base + 32'(b));
        if (sg && n == 1) v = {{24{v[7]}}, v[7:0]};
        if (sg && n == 2) v = {{16{v[15]}}, v[15:0]};
        exp_cyc = trap ? 1 : (st ? 2 : 2 + lat(i));

        @(negedge clk);
        req[i] = 1'b1; op[i] = o; addr[i] = a; wdata[i] = wd;
        @(negedge clk);
        req[i] = 1'b0;
        done_cyc = 0; wr_cnt = 0; mis_seen = 1'b0; be_seen = '0;
        for (int c = 1; c <= 20; c++) begin
            if (dm_wr[i]) wr_cnt++;
            if (c == 1) begin
                be_seen = dm_be[i];
                check("busy_c1", 32'(busy[i]), 32'd1);
                if (!trap) begin
                    check("dm_be", 32'(dm_be[i]), 32'(ebe));
                    check("dm_ue", 32'(dm_ue[i]), 32'(sg));
                    check("dm_addr", 32'(dm_addr[i]), 32'(base[ADDR_W-1:2]));
                    check("dm_din", dm_din[i], wd);
                end
            end
            if (done[i]) begin
                done_cyc = c;
                mis_seen = misalign[i];
                break;
            end
            @(negedge clk);
        end
        check("done_cycle", 32'(done_cyc), 32'(exp_cyc));
        check("wr_pulses", 32'(wr_cnt), 32'(st && !trap));
        check("misalign", 32'(mis_seen), 32'(trap));

        if (trap) exp_badv[i] = a;
        else if (st) for (int b = 0; b < int'(n); b++) rmem[{1'(i), base + 32'(b)}] = wd[8*b +: 8];
        else exp_mdr[i] = v;
        check("mdr", mdr[i], exp_mdr[i]);
        check("badvaddr", badvaddr[i], exp_badv[i]);

        @(negedge clk);
        check("done_once", 32'(done[i]), 32'd0);
        check("busy_idle", 32'(busy[i]), 32'd0);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  exp_be;
        logic        chk_mdr;
        logic [31:0] exp_mdr;
    } vec_t;

    vec_t vecs [13];

    initial begin
        logic [3:0]  be_s;
        int          dc, wr, dn;
        logic [31:0] exp_41;

        vecs[0]  = '{SW,  32'h10, 32'hDEADBEEF, 4'b1111, 1'b0, 32'h0};
        vecs[1]  = '{LW,  32'h10, 32'h0,        4'b1111, 1'b1, 32'hDEADBEEF};
        vecs[2]  = '{SW,  32'h20, 32'h80817F80, 4'b1111, 1'b0, 32'h0};
        vecs[3]  = '{LB,  32'h20, 32'h0,        4'b0001, 1'b1, 32'hFFFFFF80};
        vecs[4]  = '{LBU, 32'h20, 32'h0,        4'b0001, 1'b1, 32'h00000080};
        vecs[5]  = '{LB,  32'h21, 32'h0,        4'b0010, 1'b1, 32'h0000007F};
        vecs[6]  = '{LH,  32'h22, 32'h0,        4'b1100, 1'b1, 32'hFFFF8081};
        vecs[7]  = '{LHU, 32'h22, 32'h0,        4'b1100, 1'b1, 32'h00008081};
        vecs[8]  = '{SW,  32'h30, 32'h11223344, 4'b1111, 1'b0, 32'h0};
        vecs[9]  = '{SB,  32'h33, 32'h000000AA, 4'b1000, 1'b0, 32'h0};
        vecs[10] = '{LW,  32'h30, 32'h0,        4'b1111, 1'b1, 32'hAA223344};
        vecs[11] = '{SH,  32'h30, 32'h00001234, 4'b0011, 1'b0, 32'h0};
        vecs[12] = '{LW,  32'h30, 32'h0,        4'b1111, 1'b1, 32'hAA221234};

        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; req[i] = 1'b0; op[i] = '0; addr[i] = '0; wdata[i] = '0;
            exp_mdr[i] = '0; exp_badv[i] = '0;
        end
        mem_init = 1'b1;
        repeat (3) @(negedge clk);
        rst[0] = 1'b0; rst[1] = 1'b0; mem_init = 1'b0;

        // Reset state
        check("rst_mdr", mdr[0], 32'h0);
        check("rst_badvaddr", badvaddr[0], 32'h0);
        check("rst_dm_din", dm_din[0], 32'h0);
        check("rst_dm_addr", 32'(dm_addr[0]), 32'h0);
        check("rst_dm_be", 32'(dm_be[0]), 32'h0);
        check("rst_flags", 32'({dm_wr[0], dm_ue[0], busy[0], done[0], misalign[0]}), 32'h0);

        // Directed vector table on the RD_LAT=1 instance
        for (int t = 0; t < 13; t++) begin
            do_txn(0, vecs[t].op, vecs[t].addr, vecs[t].wdata, be_s, dc);
            check($sformatf("vec%0d_be", t), 32'(be_s), 32'(vecs[t].exp_be));
            if (vecs[t].chk_mdr) check($sformatf("vec%0d_mdr", t), mdr[0], vecs[t].exp_mdr);
        end

        // Misaligned accesses
        do_txn(0, SW, 32'h40, 32'h55667788, be_s, dc);
        do_txn(0, LW, 32'h10, 32'h0, be_s, dc);
        do_txn(0, LW, 32'h41, 32'h0, be_s, dc);
`ifdef LSU_MISALIGN_TRAP_EN
        exp_41 = 32'hDEADBEEF;
        check("mis_badvaddr", badvaddr[0], 32'h41);
`else
        exp_41 = 32'h55667788;
`endif
        check("lw41_mdr", mdr[0], exp_41);
        do_txn(0, SH, 32'h43, 32'h0000BEEF, be_s, dc);
        do_txn(0, LW, 32'h40, 32'h0, be_s, dc);

        // req held through the whole access, opcode changed mid-flight
        do_txn(0, SW, 32'h50, 32'hCAFEF00D, be_s, dc);
        @(negedge clk);
        req[0] = 1'b1; op[0] = LW; addr[0] = 32'h50;
        wr = 0; dn = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) begin op[0] = SW; wdata[0] = 32'h0; end
            if (c == 4) req[0] = 1'b0;
            if (dm_wr[0]) wr++;
            if (done[0]) dn++;
        end
        check("held_req_dones", 32'(dn), 32'd1);
        check("held_req_wr", 32'(wr), 32'd0);
        check("held_req_mdr", mdr[0], 32'hCAFEF00D);
        exp_mdr[0] = 32'hCAFEF00D;

        // Randomized accesses against the reference model
        for (int t = 0; t < 150; t++)
            do_txn(0, 3'($urandom_range(0, 7)), 32'($urandom_range(0, 255)), $urandom, be_s, dc);

        // RD_LAT=3 instance: load completes in cycle 5
        do_txn(1, SW, 32'h8, 32'h13579BDF, be_s, dc);
        do_txn(1, LW, 32'h8, 32'h0, be_s, dc);
        check("lat3_done_cycle", 32'(dc), 32'd5);
        check("lat3_mdr", mdr[1], 32'h13579BDF);

        // Reset while waiting for read data
        @(negedge clk);
        req[1] = 1'b1; op[1] = LW; addr[1] = 32'h8;
        @(negedge clk);
        req[1] = 1'b0;
        @(negedge clk);
        rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        exp_mdr[1] = '0;
        exp_badv[1] = '0;
        check("rstw_busy", 32'(busy[1]), 32'd0);
        check("rstw_dm_wr", 32'(dm_wr[1]), 32'd0);
        check("rstw_mdr", mdr[1], 32'h0);
        dn = 0;
        for (int c = 0; c < 6; c++) begin
            if (done[1]) dn++;
            @(negedge clk);
        end
        check("rstw_no_done", 32'(dn), 32'd0);
        do_txn(1, LHU, 32'hA, 32'h0, be_s, dc);
        check("post_rst_lhu", mdr[1], 32'h00001357);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
